bram_port_ctrl: RTL and testbench
=================================

BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, which sets the data width.
REQ-002 SHALL have parameter RAM_DEPTH, default 128, which sets the word count; address width is AW = $clog2(RAM_DEPTH).
REQ-003 SHALL have parameter RSP_DEPTH, default 4, which sets the response buffer entries (power of 2, >= 2).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-006 RSTn  input  1  asynchronous active-low reset.
REQ-007 i_req_valid  input  1  request present.
REQ-008 o_req_ready  output  1  request may be accepted.
REQ-009 i_req_we  input  1  1 = write, 0 = read.
REQ-010 i_req_addr  input  AW  request address.
REQ-011 i_req_wdata  input  RAM_WIDTH  write data.
REQ-012 o_rsp_valid  output  1  read response present.
REQ-013 i_rsp_ready  input  1  consumer accepts the response.
REQ-014 o_rsp_rdata  output  RAM_WIDTH  read data.
REQ-015 o_bram_we  output  1  BRAM port write enable.
REQ-016 o_bram_addr  output  AW  BRAM port address.
REQ-017 o_bram_din  output  RAM_WIDTH  BRAM port write data.
REQ-018 i_bram_dout  input  RAM_WIDTH  BRAM port registered read data (one-cycle read latency, write-through).
REQ-019 o_idle  output  1  no read outstanding and no write in the issue stage.

Function
REQ-020 SHALL treat a request as accepted at a rising edge when i_req_valid and o_req_ready are both 1 before that edge.
REQ-021 SHALL keep a credit counter (0..RSP_DEPTH): +1 on each read accept, -1 on each response handshake, unchanged when both occur in the same cycle.
REQ-022 SHALL drive o_req_ready = (credit < RSP_DEPTH) and RSTn; it SHALL apply to both reads and writes and SHALL NOT depend combinationally on i_rsp_ready.
REQ-023 Issue stage: at the accept edge E0, SHALL register o_bram_we = i_req_we, o_bram_addr = i_req_addr and o_bram_din = i_req_wdata.
REQ-024 Cycles without an accept: SHALL drive o_bram_we = 0; o_bram_addr and o_bram_din hold their last values.
REQ-025 SHALL carry a read-tag pipeline: the read tag is set at E0 for a read, i_bram_dout is valid after E1, and i_bram_dout is pushed into the response FIFO at E2.
REQ-026 Writes SHALL produce no response.
REQ-027 Response FIFO: RSP_DEPTH entries, in order; o_rsp_valid = (FIFO not empty); o_rsp_rdata = head entry.
REQ-028 Pop on o_rsp_valid and i_rsp_ready.
REQ-029 A push and a pop in the same cycle SHALL both occur.
REQ-030 Read latency: with an empty FIFO, o_rsp_valid SHALL rise in the cycle after E2, i.e. 3 cycles after the accept edge.
REQ-031 Credit accounting SHALL guarantee the FIFO never overflows.
REQ-032 FIFO read/write pointers SHALL wrap modulo RSP_DEPTH.
REQ-033 Back-to-back accepts SHALL be sustained at 1 per cycle while credit < RSP_DEPTH.
REQ-034 Ordering: a write accepted at edge E is visible to a read accepted at E+1 or later (the BRAM writes at E+1 and reads no earlier than E+2).
REQ-035 o_rsp_rdata SHALL stay stable while o_rsp_valid = 1 and i_rsp_ready = 0.
REQ-036 o_idle = (credit == 0) and not o_bram_we.

Reset
REQ-037 While RSTn = 0: o_req_ready = 0, o_rsp_valid = 0, o_bram_we = 0, o_bram_addr = 0, o_bram_din = 0, o_rsp_rdata = 0, credit = 0, FIFO pointers = 0, read tags = 0, o_idle = 1.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight reads and buffered responses; no response SHALL appear after reset release.
REQ-039 The first accept SHALL be possible at the first rising edge after RSTn deasserts.

Verification
REQ-040 Write 0xDEADBEEF to address 5 at edge E0, read address 5 at E0+1 -> one response 0xDEADBEEF, o_rsp_valid high 3 cycles after the read accept.
REQ-041 i_rsp_ready = 0, 6 reads offered back-to-back at addresses 0..5 (preloaded with 0x10..0x15) -> exactly 4 accepted, o_req_ready = 0 afterwards; raising i_rsp_ready returns 0x10..0x13 in order, then the remaining 2 are accepted.
REQ-042 Credit = 3 with a read accept and a pop in the same cycle -> credit stays 3, o_req_ready stays 1, no data lost.
REQ-043 Continuous reads of addresses 0..15 with i_rsp_ready = 1 -> one accept per cycle, 16 responses in address order, FIFO pointers wrap 4 times.
REQ-044 RSTn pulsed low with 2 reads in flight and 2 buffered -> all outputs take their reset values, no response after release, o_idle = 1.
REQ-045 Write and read to address 7 offered with i_rsp_ready toggling every cycle -> read returns the written value, and o_rsp_rdata is stable during stall cycles.

Source files
------------

// File: rtl/bram_port_ctrl.sv
// bram_port_ctrl: credit-gated request front end for a one-cycle-latency BRAM port,
// with an in-order read response FIFO.
module bram_port_ctrl #(
    parameter int RAM_WIDTH = 32,
    parameter int RAM_DEPTH = 128,
    parameter int RSP_DEPTH = 4,
    localparam int AW = $clog2(RAM_DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [AW-1:0]        i_req_addr,
    input  logic [RAM_WIDTH-1:0] i_req_wdata,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [RAM_WIDTH-1:0] o_rsp_rdata,
    output logic                 o_bram_we,
    output logic [AW-1:0]        o_bram_addr,
    output logic [RAM_WIDTH-1:0] o_bram_din,
    input  logic [RAM_WIDTH-1:0] i_bram_dout,
    output logic                 o_idle
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]        r_credit;
    logic [PW:0]          r_wp, r_rp;
    logic [RAM_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic                 r_tag0, r_tag1;
    logic                 r_bram_we;
    logic [AW-1:0]        r_bram_addr;
    logic [RAM_WIDTH-1:0] r_bram_din;
    logic                 w_acc, w_rd_acc, w_pop;

    // credit counts reads in flight plus buffered responses, so a push always has room
    assign o_req_ready = RSTn && (r_credit < CW'(RSP_DEPTH));
    assign w_acc       = i_req_valid && o_req_ready;
    assign w_rd_acc    = w_acc && !i_req_we;
    assign o_rsp_valid = (r_wp != r_rp);
    assign w_pop       = o_rsp_valid && i_rsp_ready;
    assign o_rsp_rdata = o_rsp_valid ? r_mem[r_rp[PW-1:0]] : '0;
    assign o_bram_we   = r_bram_we;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_din  = r_bram_din;
    assign o_idle      = (r_credit == '0) && !r_bram_we;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_credit    <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_tag0      <= 1'b0;
            r_tag1      <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_credit  <= r_credit + CW'(w_rd_acc) - CW'(w_pop);
            r_tag0    <= w_rd_acc;
            r_tag1    <= r_tag0;
            r_bram_we <= w_acc && i_req_we;
            if (w_acc) begin
                r_bram_addr <= i_req_addr;
                r_bram_din  <= i_req_wdata;
            end
            if (r_tag1) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (r_tag1) r_mem[r_wp[PW-1:0]] <= i_bram_dout;
    end
endmodule

// File: tb/tb_bram_port_ctrl.sv
// tb_bram_port_ctrl: directed stimulus with a response scoreboard and a BRAM model.
module tb_bram_port_ctrl;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [6:0]  i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_rdata;
    logic        o_bram_we;
    logic [6:0]  o_bram_addr;
    logic [31:0] o_bram_din;
    logic [31:0] bram_dout;
    logic        o_idle;

    logic [31:0] bram [128];
    logic [31:0] exp_q [$];
    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;
    int acc = 0;

    bram_port_ctrl dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_din(o_bram_din),
        .i_bram_dout(bram_dout), .o_idle(o_idle)
    );

    always #5 CLK = ~CLK;

    // write-through BRAM with one-cycle registered read
    always @(posedge CLK) begin
        if (o_bram_we) bram[o_bram_addr] <= o_bram_din;
        bram_dout <= o_bram_we ? o_bram_din : bram[o_bram_addr];
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (i_req_valid && o_req_ready) acc <= acc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge CLK) begin
        if (RSTn && o_rsp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", o_rsp_rdata, 32'hxxxxxxxx);
            else begin
                chk("rsp_data", o_rsp_rdata, exp_q[0]);
                if (i_rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic we, input logic [6:0] a, input logic [31:0] d, input logic [31:0] e);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_we = we;
        i_req_addr = a;
        i_req_wdata = d;
        @(negedge CLK);
        while (!o_req_ready && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (!o_req_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            i_req_valid = 1'b0;
        end else begin
            @(posedge CLK);
            if (!we) exp_q.push_back(e);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge CLK);
        while ((exp_q.size() != 0 || !o_idle) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n == 100) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, t0;
        i_req_valid = 1'b1;
        i_req_we = 1'b1;
        i_req_addr = 7'd0;
        i_req_wdata = 32'h10;
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_bram_we", {31'd0, o_bram_we}, 32'd0);
        chk("rst_bram_addr", {25'd0, o_bram_addr}, 32'd0);
        chk("rst_bram_din", o_bram_din, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_idle", {31'd0, o_idle}, 32'd1);
        RSTn = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, o_req_ready}, 32'd1);
        @(posedge CLK);
        #1;
        chk("first_accept_we", {31'd0, o_bram_we}, 32'd1);
        chk("first_accept_din", o_bram_din, 32'h10);
        for (int i = 1; i < 16; i++) send(1'b1, 7'(i), 32'h10 + i, 32'd0);
        send(1'b1, 7'd100, 32'h99, 32'd0);
        i_req_valid = 1'b0;
        @(negedge CLK);
        chk("wr_bram_we", {31'd0, o_bram_we}, 32'd1);
        chk("wr_bram_addr", {25'd0, o_bram_addr}, 32'd100);
        chk("wr_bram_din", o_bram_din, 32'h99);
        chk("wr_not_idle", {31'd0, o_idle}, 32'd0);
        @(negedge CLK);
        chk("hold_we_low", {31'd0, o_bram_we}, 32'd0);
        chk("hold_addr", {25'd0, o_bram_addr}, 32'd100);
        drain();

        // credit exhaustion with the consumer stalled
        i_rsp_ready = 1'b0;
        a0 = acc;
        for (int i = 0; i < 4; i++) send(1'b0, 7'(i), 32'd0, 32'h10 + i);
        i_req_valid = 1'b1;
        i_req_addr = 7'd4;
        repeat (4) @(negedge CLK);
        chk("full_not_ready", {31'd0, o_req_ready}, 32'd0);
        chk("full_accepts", acc - a0, 32'd4);
        chk("full_not_idle", {31'd0, o_idle}, 32'd0);
        i_rsp_ready = 1'b1;
        send(1'b0, 7'd4, 32'd0, 32'h14);
        send(1'b0, 7'd5, 32'd0, 32'h15);
        drain();

        // simultaneous read accept and pop at credit 3
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 7'(i), 32'd0, 32'h10 + i);
        i_req_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        i_rsp_ready = 1'b1;
        send(1'b0, 7'd3, 32'd0, 32'h13);
        i_rsp_ready = 1'b0;
        i_req_valid = 1'b0;
        @(negedge CLK);
        chk("credit3_ready", {31'd0, o_req_ready}, 32'd1);
        @(posedge CLK);
        #1;
        send(1'b0, 7'd4, 32'd0, 32'h14);
        i_req_valid = 1'b0;
        @(negedge CLK);
        chk("credit4_not_ready", {31'd0, o_req_ready}, 32'd0);
        drain();

        // streaming reads, pointers wrap
        i_rsp_ready = 1'b1;
        a0 = acc;
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(1'b0, 7'(i), 32'd0, 32'h10 + i);
        chk("stream_cycles", cyc - t0, 32'd16);
        chk("stream_accepts", acc - a0, 32'd16);
        drain();

        // write then read-after-write latency
        send(1'b1, 7'd5, 32'hDEADBEEF, 32'd0);
        send(1'b0, 7'd5, 32'd0, 32'hDEADBEEF);
        i_req_valid = 1'b0;
        @(negedge CLK);
        chk("lat_c1", {31'd0, o_rsp_valid}, 32'd0);
        @(negedge CLK);
        chk("lat_c2", {31'd0, o_rsp_valid}, 32'd0);
        @(negedge CLK);
        chk("lat_c3", {31'd0, o_rsp_valid}, 32'd1);
        drain();

        // toggling consumer, stall stability checked by the monitor
        i_rsp_ready = 1'b0;
        fork
            begin
                send(1'b1, 7'd7, 32'hCAFE0007, 32'd0);
                send(1'b0, 7'd7, 32'd0, 32'hCAFE0007);
                send(1'b0, 7'd1, 32'd0, 32'h11);
                send(1'b0, 7'd7, 32'd0, 32'hCAFE0007);
                i_req_valid = 1'b0;
            end
            repeat (20) begin
                @(posedge CLK);
                #1;
                i_rsp_ready = ~i_rsp_ready;
            end
        join
        drain();

        // reset with two reads in flight and two buffered
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 7'(i), 32'd0, 32'h10 + i);
        RSTn = 1'b0;
        i_req_valid = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("mid_rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, o_req_ready}, 32'd0);
        chk("mid_rst_rdata", o_rsp_rdata, 32'd0);
        chk("mid_rst_bram_addr", {25'd0, o_bram_addr}, 32'd0);
        chk("mid_rst_idle", {31'd0, o_idle}, 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        i_rsp_ready = 1'b1;
        repeat (6) begin
            @(negedge CLK);
            chk("no_rsp_after_rst", {31'd0, o_rsp_valid}, 32'd0);
        end
        chk("post_rst_idle", {31'd0, o_idle}, 32'd1);
        chk("post_rst_ready", {31'd0, o_req_ready}, 32'd1);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
